// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The master drives the request, and the slave (the adder) returns status and result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (output start, A, B, Cin, input busy, done, Sum, Cout, Ovf);
    modport slave  (input start, A, B, Cin, output busy, done, Sum, Cout, Ovf);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder.
// One full-adder cell plus a carry flop resolves one bit per clock, LSB first.
// Sum, Cout and Ovf are held in result registers that update only on completion.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MSB_M1 = CW'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rega_q, rega_d;
    logic [WIDTH-1:0] regb_q, regb_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;   // carry into the MSB, used for Ovf
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic s_bit, c_bit, accept;

    // Single full-adder cell working on the current LSBs.
    assign s_bit  = rega_q[0] ^ regb_q[0] ^ carry_q;
    assign c_bit  = (rega_q[0] & regb_q[0]) | (carry_q & (rega_q[0] ^ regb_q[0]));
    // A start is ignored while an addition is in progress; in DONE it chains back-to-back.
    assign accept = bus.start && (state_q != RUN);

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d = state_q;
        rega_d  = rega_q;
        regb_d  = regb_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                psum_d  = {s_bit, psum_q[WIDTH-1:1]};
                rega_d  = rega_q >> 1;
                regb_d  = regb_q >> 1;
                carry_d = c_bit;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == MSB_M1) cmsb_d = c_bit;
                if (cnt_q == LAST) begin
                    sum_d   = {s_bit, psum_q[WIDTH-1:1]};
                    cout_d  = c_bit;
                    ovf_d   = cmsb_q ^ c_bit;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            rega_d  = bus.A;
            regb_d  = bus.B;
            carry_d = bus.Cin;
            psum_d  = '0;
            cnt_d   = '0;
            cmsb_d  = 1'b0;
            state_d = RUN;
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rega_q  <= '0;
            regb_q  <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rega_q  <= rega_d;
            regb_q  <= regb_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
    assign bus.Ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=2 instances.
// Expected results are queued when a start is driven and compared when done pulses.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    typedef struct { int sum; int cout; int ovf; int acc; } exp_t;
    typedef struct { int a; int b; int cin; int sum; int cout; int ovf; } vec_t;

    exp_t q8[$];
    exp_t q2[$];

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(2)) if2 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    always #5 clk = ~clk;

    // Cycle counter used to check the completion latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic void model(input int w, input int a, input int b, input int cin,
                                  output int s, output int co, output int ov);
        int full, half, sa, sb, ss;
        full = a + b + cin;
        half = 1 << (w - 1);
        sa = (a >= half) ? a - 2 * half : a;
        sb = (b >= half) ? b - 2 * half : b;
        ss = sa + sb + cin;
        s  = full % (2 * half);
        co = full / (2 * half);
        ov = (ss > half - 1 || ss < -half) ? 1 : 0;
    endfunction

    // Scoreboard for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (if8.done === 1'b1) begin
            if (q8.size() == 0) begin
                chk("done8_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("sum8", int'(if8.Sum), e.sum);
                chk("cout8", int'(if8.Cout), e.cout);
                chk("ovf8", int'(if8.Ovf), e.ovf);
                chk("latency8", cyc - e.acc, 8);
            end
        end else if (q8.size() > 0 && cyc > q8[0].acc + 8) begin
            chk("done8_missing", 0, 1);
            void'(q8.pop_front());
        end
    end

    // Scoreboard for the WIDTH=2 instance.
    always @(negedge clk) begin
        if (if2.done === 1'b1) begin
            if (q2.size() == 0) begin
                chk("done2_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("sum2", int'(if2.Sum), e.sum);
                chk("cout2", int'(if2.Cout), e.cout);
                chk("ovf2", int'(if2.Ovf), e.ovf);
                chk("latency2", cyc - e.acc, 2);
            end
        end else if (q2.size() > 0 && cyc > q2[0].acc + 2) begin
            chk("done2_missing", 0, 1);
            void'(q2.pop_front());
        end
    end

    // Drive one start from a negedge; returns at the following negedge.
    task automatic start8(input int a, input int b, input int cin,
                          input int es, input int ec, input int eo);
        if8.A = 8'(a); if8.B = 8'(b); if8.Cin = 1'(cin); if8.start = 1'b1;
        q8.push_back('{es, ec, eo, cyc + 1});
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    task automatic start2(input int a, input int b, input int cin,
                          input int es, input int ec, input int eo);
        if2.A = 2'(a); if2.B = 2'(b); if2.Cin = 1'(cin); if2.start = 1'b1;
        q2.push_back('{es, ec, eo, cyc + 1});
        @(negedge clk);
        if2.start = 1'b0;
    endtask

    task automatic wait_q8();
        int n = 0;
        while (q8.size() > 0 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("wait8_timeout", 0, 1);
    endtask

    task automatic wait_q2();
        int n = 0;
        while (q2.size() > 0 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("wait2_timeout", 0, 1);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hard stop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int s, co, ov, a, b, ci, n;

        tbl[0] = '{'h35, 'h0A, 0, 'h3F, 0, 0};
        tbl[1] = '{'hFF, 'h00, 1, 'h00, 1, 0};
        tbl[2] = '{'h7F, 'h01, 0, 'h80, 0, 1};
        tbl[3] = '{'h80, 'h80, 0, 'h00, 1, 1};
        tbl[4] = '{'hFF, 'hFF, 1, 'hFF, 1, 0};
        tbl[5] = '{'h40, 'h40, 0, 'h80, 0, 1};
        tbl[6] = '{'hC0, 'hC0, 0, 'h80, 1, 0};

        if8.start = 1'b1; if8.A = 8'hAA; if8.B = 8'h55; if8.Cin = 1'b1;
        if2.start = 1'b1; if2.A = 2'h3;  if2.B = 2'h1;  if2.Cin = 1'b1;

        // Reset held for two cycles with start asserted.
        rst_n = 1'b0;
        ticks(2);
        chk("rst_busy", int'(if8.busy), 0);
        chk("rst_done", int'(if8.done), 0);
        chk("rst_sum",  int'(if8.Sum), 0);
        chk("rst_cout", int'(if8.Cout), 0);
        chk("rst_ovf",  int'(if8.Ovf), 0);
        chk("rst_busy2", int'(if2.busy), 0);
        if8.start = 1'b0; if2.start = 1'b0;
        rst_n = 1'b1;
        ticks(3);
        chk("idle_busy", int'(if8.busy), 0);
        chk("idle_done", int'(if8.done), 0);

        // Table of directed vectors.
        for (int i = 0; i < 7; i++) begin
            start8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, tbl[i].ovf);
            chk("busy_after_start", int'(if8.busy), 1);
            wait_q8();
            ticks(1);
        end

        // Sum holds after done and through the next RUN.
        start8('h35, 'h0A, 0, 'h3F, 0, 0);
        wait_q8();
        ticks(3);
        chk("hold_idle_sum", int'(if8.Sum), 'h3F);
        start8('h01, 'h02, 0, 'h03, 0, 0);
        ticks(3);
        chk("hold_run_sum", int'(if8.Sum), 'h3F);
        wait_q8();
        ticks(1);

        // A start pulse during RUN is ignored.
        start8('h12, 'h34, 0, 'h46, 0, 0);
        ticks(2);
        if8.A = 8'hFF; if8.B = 8'hFF; if8.Cin = 1'b0; if8.start = 1'b1;
        ticks(1);
        if8.start = 1'b0;
        wait_q8();
        ticks(4);

        // Back-to-back: new start during the done cycle.
        start8('h20, 'h22, 0, 'h42, 0, 0);
        n = 0;
        while (if8.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("b2b_done_seen", int'(n < 20), 1);
        start8('h01, 'h01, 0, 'h02, 0, 0);
        chk("b2b_busy", int'(if8.busy), 1);
        chk("b2b_nodone", int'(if8.done), 0);
        wait_q8();
        ticks(1);

        // Reset mid-operation abandons the result.
        start8('h55, 'h22, 0, 'h77, 0, 0);
        ticks(3);
        rst_n = 1'b0;
        q8.delete();
        ticks(1);
        chk("mid_rst_busy", int'(if8.busy), 0);
        chk("mid_rst_done", int'(if8.done), 0);
        chk("mid_rst_sum",  int'(if8.Sum), 0);
        rst_n = 1'b1;
        ticks(12);
        start8('h10, 'h20, 0, 'h30, 0, 0);
        wait_q8();
        ticks(1);

        // Randomised, WIDTH=8.
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(255)); b = int'($urandom_range(255)); ci = int'($urandom_range(1));
            model(8, a, b, ci, s, co, ov);
            start8(a, b, ci, s, co, ov);
            wait_q8();
        end

        // WIDTH=2: exhaustive-ish random plus a corner.
        start2(1, 1, 0, 2, 0, 1);
        wait_q2();
        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(3)); b = int'($urandom_range(3)); ci = int'($urandom_range(1));
            model(2, a, b, ci, s, co, ov);
            start2(a, b, ci, s, co, ov);
            wait_q2();
        end
        ticks(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
